// File: rtl/fetch_pc_unit.sv
// Program counter and fetch control in front of the instruction memory: sequential fetch,
// stall, redirect with flush, HALT detection. Optional call/return stack under FETCH_CALL_STACK_EN.
module fetch_pc_unit #(
    parameter int                ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [4:0]        HALT_OPCODE = 5'h1F,
    parameter int                STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic [4:0]        opcode,
    input  logic              resume,
    input  logic              call,
    input  logic              ret,
    output logic [ADDR_W-1:0] Address,
    output logic              instRead,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              halted,
    output logic              wrap,
    output logic              stack_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic              wrap_q, wrap_d;
    logic              inst_read;
    logic              halt_hit;
    logic              call_eff;
    logic              ret_eff;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] pop_addr;

    assign halt_hit = (state_q == ST_FETCH) && valid_q && (opcode == HALT_OPCODE);

`ifdef FETCH_CALL_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] stk_q [STACK_DEPTH];
    logic [SP_W-1:0]   sp_q;
    logic              err_q;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  top_idx;
    logic              stk_full;
    logic              stk_empty;

    assign call_eff  = call;
    assign ret_eff   = ret;
    assign push_idx  = sp_q[IDX_W-1:0];
    assign top_idx   = sp_q[IDX_W-1:0] - IDX_W'(1);
    assign stk_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stk_empty = (sp_q == '0);
    assign pop_addr  = stk_empty ? RESET_PC : stk_q[top_idx];
    assign stack_err = err_q;

    // A push into a full stack overwrites the top entry; a pop from empty leaves sp at 0.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sp_q  <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
        end else if (push) begin
            if (stk_full) begin
                stk_q[STACK_DEPTH-1] <= inst_pc_q + ADDR_W'(1);
                err_q                <= 1'b1;
            end else begin
                stk_q[push_idx] <= inst_pc_q + ADDR_W'(1);
                sp_q            <= sp_q + SP_W'(1);
            end
        end else if (pop) begin
            if (stk_empty) err_q <= 1'b1;
            else           sp_q  <= sp_q - SP_W'(1);
        end
    end
`else
    logic unused_stack_in;

    assign call_eff        = 1'b0;
    assign ret_eff         = 1'b0;
    assign pop_addr        = RESET_PC;
    assign stack_err       = 1'b0;
    assign unused_stack_in = call ^ ret;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;
        halted_d  = halted_q;
        wrap_d    = 1'b0;
        inst_read = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (halt_hit) begin
                    state_d  = ST_HALT;
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                end else if (redirect) begin
                    addr_d  = redirect_addr;
                    valid_d = 1'b0;
                    push    = call_eff;
                end else if (ret_eff) begin
                    addr_d  = pop_addr;
                    valid_d = 1'b0;
                    pop     = 1'b1;
                end else if (!stall) begin
                    inst_read = 1'b1;
                    inst_pc_d = addr_q;
                    valid_d   = 1'b1;
                    addr_d    = addr_q + ADDR_W'(1);
                    wrap_d    = (addr_q == '1);
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d  = ST_FETCH;
                    halted_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= RESET_PC;
            inst_pc_q <= '0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
            halted_q  <= halted_d;
            wrap_q    <= wrap_d;
        end
    end

    assign Address    = addr_q;
    assign instRead   = inst_read;
    assign inst_valid = valid_q;
    assign inst_pc    = inst_pc_q;
    assign halted     = halted_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit; the stack section is built only with FETCH_CALL_STACK_EN.
module tb_fetch_pc_unit;

    logic       clk = 1'b0;
    logic       Reset;
    logic       stall, redirect, resume, call, ret;
    logic [7:0] redirect_addr;
    logic [4:0] opcode;
    logic [7:0] Address, inst_pc;
    logic       instRead, inst_valid, halted, wrap, stack_err;

    int n_checks = 0;
    int n_errors = 0;

    fetch_pc_unit dut (
        .clk           (clk),
        .Reset         (Reset),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .opcode        (opcode),
        .resume        (resume),
        .call          (call),
        .ret           (ret),
        .Address       (Address),
        .instRead      (instRead),
        .inst_valid    (inst_valid),
        .inst_pc       (inst_pc),
        .halted        (halted),
        .wrap          (wrap),
        .stack_err     (stack_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        stall = 0; redirect = 0; resume = 0; call = 0; ret = 0;
        redirect_addr = 8'h00; opcode = 5'h00;
        do_reset();

        // reset values, then IDLE for one cycle
        chk("rst_addr", Address, 8'h00);
        chk("rst_pc", inst_pc, 8'h00);
        chk("rst_valid", inst_valid, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_wrap", wrap, 1'b0);
        chk("rst_err", stack_err, 1'b0);
        chk("idle_read", instRead, 1'b0);
        tick();
        chk("fetch0_addr", Address, 8'h00);
        chk("fetch0_valid", inst_valid, 1'b0);
        chk("fetch0_read", instRead, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("seq_addr", Address, 32'(k));
            chk("seq_pc", inst_pc, 32'(k - 1));
            chk("seq_valid", inst_valid, 1'b1);
        end

        // stall for three cycles at Address 05
        stall = 1;
        #1 chk("stall_read", instRead, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_addr", Address, 8'h05);
            chk("stall_pc", inst_pc, 8'h04);
            chk("stall_valid", inst_valid, 1'b1);
        end
        stall = 0;
        #1 chk("unstall_read", instRead, 1'b1);
        tick();
        chk("unstall_addr", Address, 8'h06);
        chk("unstall_pc", inst_pc, 8'h05);
        tick();
        chk("pre_redir_addr", Address, 8'h07);

        // redirect to 40
        redirect = 1; redirect_addr = 8'h40;
        #1 chk("redir_read", instRead, 1'b0);
        tick();
        redirect = 0;
        chk("redir_addr", Address, 8'h40);
        chk("redir_valid", inst_valid, 1'b0);
        chk("redir_pc_hold", inst_pc, 8'h06);
        tick();
        chk("redir_next_addr", Address, 8'h41);
        chk("redir_next_pc", inst_pc, 8'h40);
        chk("redir_next_valid", inst_valid, 1'b1);

        // redirect beats stall
        stall = 1; redirect = 1; redirect_addr = 8'h30;
        tick();
        stall = 0; redirect = 0;
        chk("redir_over_stall", Address, 8'h30);

        // wrap FE -> FF -> 00
        redirect = 1; redirect_addr = 8'hFE;
        tick();
        redirect = 0;
        chk("wrap_tgt", Address, 8'hFE);
        tick();
        chk("wrap_a_addr", Address, 8'hFF);
        chk("wrap_a_pc", inst_pc, 8'hFE);
        chk("wrap_a_flag", wrap, 1'b0);
        tick();
        chk("wrap_b_addr", Address, 8'h00);
        chk("wrap_b_pc", inst_pc, 8'hFF);
        chk("wrap_b_flag", wrap, 1'b1);
        tick();
        chk("wrap_c_addr", Address, 8'h01);
        chk("wrap_c_pc", inst_pc, 8'h00);
        chk("wrap_c_flag", wrap, 1'b0);

        // HALT at inst_pc 10, also outranking a same-cycle redirect
        redirect = 1; redirect_addr = 8'h10;
        tick();
        redirect = 0;
        tick();
        chk("pre_halt_pc", inst_pc, 8'h10);
        chk("pre_halt_addr", Address, 8'h11);
        opcode = 5'h1F; redirect = 1; redirect_addr = 8'h99;
        #1 chk("halt_hit_read", instRead, 1'b0);
        tick();
        opcode = 5'h00;
        chk("halt_flag", halted, 1'b1);
        chk("halt_valid", inst_valid, 1'b0);
        chk("halt_addr", Address, 8'h11);
        redirect_addr = 8'h55; stall = 1;
        tick();
        redirect = 0; stall = 0;
        chk("halt_ign_addr", Address, 8'h11);
        chk("halt_ign_flag", halted, 1'b1);
        chk("halt_read", instRead, 1'b0);
        resume = 1;
        tick();
        resume = 0;
        chk("resume_flag", halted, 1'b0);
        chk("resume_addr", Address, 8'h11);
        chk("resume_read", instRead, 1'b1);
        tick();
        chk("resume_fetch_addr", Address, 8'h12);
        chk("resume_fetch_pc", inst_pc, 8'h11);
        chk("resume_fetch_valid", inst_valid, 1'b1);

        // opcode 1F without a valid instruction does not halt
        redirect = 1; redirect_addr = 8'h60;
        tick();
        redirect = 0; opcode = 5'h1F;
        #1 chk("nohalt_read", instRead, 1'b1);
        tick();
        opcode = 5'h00;
        chk("nohalt_flag", halted, 1'b0);
        chk("nohalt_addr", Address, 8'h61);

        // asynchronous reset mid-run
        #2 Reset = 1;
        #1 chk("async_rst_addr", Address, 8'h00);
        chk("async_rst_valid", inst_valid, 1'b0);
        tick();
        Reset = 0;
        tick();

`ifdef FETCH_CALL_STACK_EN
        redirect = 1; redirect_addr = 8'h20;
        tick();
        redirect = 0;
        tick();
        chk("call_src_pc", inst_pc, 8'h20);
        call = 1; redirect = 1; redirect_addr = 8'h80;
        tick();
        call = 0; redirect = 0;
        chk("call_addr", Address, 8'h80);
        tick();
        chk("callee_pc", inst_pc, 8'h80);
        ret = 1;
        #1 chk("ret_read", instRead, 1'b0);
        tick();
        ret = 0;
        chk("ret_addr", Address, 8'h21);
        chk("ret_valid", inst_valid, 1'b0);
        chk("ret_err", stack_err, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            call = 1; redirect = 1; redirect_addr = 8'(8'h80 + k);
            tick();
            call = 0; redirect = 0;
            tick();
            chk("nest_err", stack_err, (k == 5) ? 1'b1 : 1'b0);
        end
        do_reset();
        chk("err_cleared", stack_err, 1'b0);
        tick();
        ret = 1;
        tick();
        ret = 0;
        chk("underflow_addr", Address, 8'h00);
        chk("underflow_err", stack_err, 1'b1);
`else
        ret = 1; call = 1;
        #1 chk("noret_read", instRead, 1'b1);
        tick();
        chk("noret_addr", Address, 8'h01);
        redirect = 1; redirect_addr = 8'h80;
        tick();
        ret = 0; call = 0; redirect = 0;
        chk("nocall_addr", Address, 8'h80);
        chk("nostack_err", stack_err, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
